// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC constants for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // One bit of an MSB-first CRC-8 update.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_rb_crc8.sv
// Bit-serial CRC-8 accumulator over the chain tail stream.
module ccff_rb_crc8
    import ccff_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            crc <= CRC8_INIT;
        else if (en)
            crc <= crc8_step(crc, din);
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first into the ccff chain head and gates prog_clk.
// Optional tail readback CRC is enabled by defining CCFF_READBACK_EN.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 36,
    parameter int DATA_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              cfg_done,
    output logic [7:0]        rb_crc
);

    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int LEFT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);

    state_t              state, next_state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [LEFT_W-1:0]   bits_left;
    logic [LEFT_W-1:0]   take;
    logic [DATA_W-1:0]   shreg;
    logic [31:0]         remain;
    logic                start_acc;
    logic                accept;
    logic                shift;
    logic                last_shift;

    assign start_acc  = start && (state != LOAD);
    assign shift      = (bits_left != '0);
    assign accept     = s_valid && s_ready;
    assign last_shift = shift && (bit_cnt == LAST_C);

    // Final word of a load only contributes what the chain still needs.
    always_comb begin
        remain = 32'(CHAIN_LEN) - 32'(bit_cnt);
        take   = (remain < 32'(DATA_W)) ? LEFT_W'(remain) : LEFT_W'(DATA_W);
    end

    always_ff @(posedge prog_clk) begin
        if (pReset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (last_shift) next_state = DONE;
            DONE:    if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == LOAD);
        s_ready     = busy && (bits_left == '0) && (bit_cnt < LEN_C);
        ccff_clk_en = shift;
        ccff_head   = shift && shreg[0];
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bit_cnt   <= '0;
            bits_left <= '0;
            shreg     <= '0;
            cfg_done  <= 1'b0;
        end else begin
            if (start_acc) begin
                bit_cnt  <= '0;
                cfg_done <= 1'b0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (last_shift)
                    cfg_done <= 1'b1;
            end
            // Accept and shift are exclusive: s_ready requires bits_left==0.
            if (accept) begin
                shreg     <= s_data;
                bits_left <= take;
            end else if (shift) begin
                shreg     <= shreg >> 1;
                bits_left <= bits_left - LEFT_W'(1);
            end
        end
    end

`ifdef CCFF_READBACK_EN
    ccff_rb_crc8 u_rb_crc (
        .clk (prog_clk),
        .rst (pReset),
        .en  (ccff_clk_en),
        .clr (start_acc),
        .din (ccff_tail),
        .crc (rb_crc)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign rb_crc      = 8'h00;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised self-checking bench: word list -> expected LSB-first bit stream, chain model for readback.
module tb_ccff_chain_loader;

    localparam int CL = 36;

    logic       clk = 1'b0;
    logic       p_reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_valid = 1'b0;
    logic       s_ready, head, clk_en, tail, busy, cfg_done;
    logic [7:0] rb_crc;

    logic       d1_start = 1'b0;
    logic [7:0] d1_data = '0;
    logic       d1_valid = 1'b0;
    logic       d1_ready, d1_head, d1_en, d1_busy, d1_done;
    logic       d1_tail = 1'b0;
    logic [7:0] d1_crc;

    always #5 clk = ~clk;

    ccff_chain_loader #(.CHAIN_LEN(CL), .DATA_W(8)) dut (
        .prog_clk(clk), .pReset(p_reset), .start(start), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .ccff_head(head), .ccff_clk_en(clk_en), .ccff_tail(tail),
        .busy(busy), .cfg_done(cfg_done), .rb_crc(rb_crc)
    );

    ccff_chain_loader #(.CHAIN_LEN(1), .DATA_W(8)) dut1 (
        .prog_clk(clk), .pReset(p_reset), .start(d1_start), .s_data(d1_data), .s_valid(d1_valid),
        .s_ready(d1_ready), .ccff_head(d1_head), .ccff_clk_en(d1_en), .ccff_tail(d1_tail),
        .busy(d1_busy), .cfg_done(d1_done), .rb_crc(d1_crc)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Observed chain traffic and a 36-stage model of the downstream chain.
    logic [7:0]  words[$];
    bit          obs[$];
    int          done_at = -1;
    logic [35:0] chain = '0;
    int          d1_pulses = 0;
    logic        d1_bit = 1'b0;

    assign tail = chain[CL-1];

    always @(posedge clk) if (clk_en) chain <= {chain[CL-2:0], head};

    always @(negedge clk) begin
        if (clk_en) obs.push_back(head);
        if (cfg_done && done_at < 0) done_at = obs.size();
        if (d1_en) begin d1_pulses++; d1_bit = d1_head; end
    end

    function automatic logic [35:0] exp_bits();
        logic [35:0] v = '0;
        int pos = 0;
        foreach (words[i])
            for (int b = 0; b < 8; b++)
                if (pos < CL) begin v[pos] = words[i][b]; pos++; end
        return v;
    endfunction

    function automatic logic [35:0] obs_bits();
        logic [35:0] v = '0;
        foreach (obs[i]) if (i < CL) v[i] = obs[i];
        return v;
    endfunction

    function automatic logic [7:0] crc_ref(input logic [35:0] bits);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < CL; i++)
            c = ((c << 1) & 8'hFF) ^ (((c >> 7) ^ 8'(bits[i])) != 0 ? 8'h07 : 8'h00);
        return c;
    endfunction

    task automatic rand_words();
        words.delete();
        for (int i = 0; i < 5; i++) words.push_back(8'($urandom));
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        obs.delete();
        done_at = -1;
    endtask

    task automatic load(input int gap, input int abort_at);
        int idx = 0;
        int cyc = 0;
        int gap_err = 0;
        logic acc;
        s_data = words[0];
        s_valid = 1'b1;
        while (idx < words.size() && cyc < 2000 && obs.size() < abort_at) begin
            @(negedge clk); acc = s_ready;
            @(posedge clk); #1; cyc++;
            if (acc) begin
                idx++;
                if (idx < words.size()) s_data = words[idx];
                if (gap > 0 && idx < words.size()) begin
                    s_valid = 1'b0;
                    for (int c = 0; c < 100 && !s_ready; c++) @(negedge clk);
                    repeat (gap) begin @(negedge clk); if (clk_en) gap_err++; end
                    @(posedge clk); #1 s_valid = 1'b1;
                end
            end
        end
        s_valid = 1'b0;
        if (gap > 0) chk("gap_clk_en", gap_err, 0);
    endtask

    task automatic wait_done(input string tag);
        for (int c = 0; c < 300 && done_at < 0; c++) begin @(posedge clk); #1; end
        chk({tag, "_done_at"}, done_at, CL);
        chk({tag, "_pulses"}, obs.size(), CL);
        chk({tag, "_bits"}, obs_bits(), exp_bits());
        @(negedge clk);
        chk({tag, "_state"}, {cfg_done, busy, s_ready, clk_en}, 4'b1000);
    endtask

    initial begin
        int nrdy;
        logic [35:0] x_bits;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {busy, s_ready, clk_en, head, cfg_done, rb_crc}, 13'h0);
        chk("reset_outs_d1", {d1_busy, d1_ready, d1_en, d1_done, d1_crc}, 12'h0);
        @(posedge clk); #1 p_reset = 1'b0;

        // 1: directed words back-to-back
        words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h09};
        do_start();
        load(0, 1000);
        wait_done("t1");

        // 2: 3-cycle valid gaps between random words
        rand_words();
        do_start();
        load(3, 1000);
        wait_done("t2");

        // 3: reset after 17 bits, then a full reload
        rand_words();
        do_start();
        load(0, 17);
        p_reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t3_reset_outs", {busy, s_ready, clk_en, head, cfg_done, rb_crc}, 13'h0);
        chk("t3_bits_before_reset", obs.size() >= 17, 1);
        @(posedge clk); #1 p_reset = 1'b0;
        rand_words();
        do_start();
        load(0, 1000);
        wait_done("t3");

        // 4: start during LOAD is ignored, words offered in DONE are refused
        rand_words();
        do_start();
        fork
            load(0, 1000);
            begin repeat (12) @(posedge clk); #1 start = 1'b1; @(posedge clk); #1 start = 1'b0; end
        join
        wait_done("t4");
        s_data = 8'($urandom);
        s_valid = 1'b1;
        nrdy = 0;
        repeat (5) begin @(negedge clk); if (s_ready || clk_en) nrdy++; end
        s_valid = 1'b0;
        chk("t4_done_offer", nrdy, 0);
        chk("t4_done_no_pulses", obs.size(), CL);
        rand_words();
        do_start();
        load(0, 1000);
        wait_done("t4_reload");

        // 5: load X twice; readback of the reload is the CRC of X
        rand_words();
        x_bits = exp_bits();
        do_start();
        load(0, 1000);
        wait_done("t5a");
        do_start();
        load(0, 1000);
        wait_done("t5b");
`ifdef CCFF_READBACK_EN
        chk("t5_rb_crc", rb_crc, crc_ref(x_bits));
`else
        chk("t5_rb_crc_off", rb_crc, 8'h00);
        chk("t5_x_reloaded", obs_bits(), x_bits);
`endif

        // 6: single-bit chain
        @(posedge clk); #1 d1_start = 1'b1;
        @(posedge clk); #1 d1_start = 1'b0;
        d1_pulses = 0;
        d1_data = 8'($urandom);
        d1_valid = 1'b1;
        for (int c = 0; c < 50 && !d1_done; c++) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t6_done", {d1_done, d1_busy, d1_ready, d1_en}, 4'b1000);
        chk("t6_pulses", d1_pulses, 1);
        chk("t6_bit", d1_bit, d1_data[0]);
        d1_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
